// File: rtl/mix_column_iter.sv
// Iterative S-AES MixColumns engine: forward or inverse matrix, one 8-bit
// column transformed per clock, with valid/ready handshakes on both sides.
//
//   state | meaning
//   IDLE  | waiting for an input state, in_ready high
//   BUSY  | transforming column col_cnt of the working register
//   DONE  | result held on out_data with out_valid until out_ready
module mix_column_iter #(
    parameter int COLS = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_dec,
    input  logic [8*COLS-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [8*COLS-1:0] out_data,
    output logic              busy
);

    localparam int SW = 8 * COLS;
    localparam int CW = $clog2((COLS > 1) ? COLS : 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [CW-1:0]   col_cnt;
    logic            mode;
    logic [SW-1:0]   work;
    logic [SW-1:0]   work_nxt;

    // GF(2^4) helpers, modulus x^4+x+1
    function automatic logic [3:0] gf_x2(input logic [3:0] v);
        return {v[2:0], 1'b0} ^ (v[3] ? 4'h3 : 4'h0);
    endfunction

    function automatic logic [3:0] gf_x4(input logic [3:0] v);
        return gf_x2(gf_x2(v));
    endfunction

    function automatic logic [3:0] gf_x9(input logic [3:0] v);
        return gf_x2(gf_x4(v)) ^ v;
    endfunction

    function automatic logic [7:0] mix_col(input logic [7:0] c, input logic dec);
        logic [3:0] s0;
        logic [3:0] s1;
        s0 = c[7:4];
        s1 = c[3:0];
        if (dec)
            return {gf_x9(s0) ^ gf_x2(s1), gf_x2(s0) ^ gf_x9(s1)};
        else
            return {s0 ^ gf_x4(s1), gf_x4(s0) ^ s1};
    endfunction

    // Working register with only the selected column replaced
    always_comb begin
        work_nxt = work;
        for (int k = 0; k < COLS; k++) begin
            if (col_cnt == CW'(k))
                work_nxt[SW-1-8*k -: 8] = mix_col(work[SW-1-8*k -: 8], mode);
        end
    end

    // Sequencer with registered handshake and status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            col_cnt   <= '0;
            mode      <= 1'b0;
            work      <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        work     <= in_data;
                        mode     <= in_dec;
                        col_cnt  <= '0;
                        state    <= BUSY;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                BUSY: begin
                    work <= work_nxt;
                    if (col_cnt == CW'(COLS - 1)) begin
                        // counter parks at 0 so it never runs past COLS-1
                        col_cnt   <= '0;
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end else begin
                        col_cnt <= col_cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    col_cnt   <= '0;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    assign out_data = work;

endmodule
